// File: rtl/tft_lcd_timing_gen.sv
// tft_lcd_timing_gen: TFT panel timing generator with pixel-stream alignment; colour bars when TFT_TIMING_TEST_PATTERN_EN is defined
module tft_lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        PIX_VALID,
    output logic        PIX_READY,
    input  logic [23:0] PIX_DATA,
    input  logic        PIX_SOF,
    input  logic        CLR_STATUS,
    output logic        TFT_PCLK,
    output logic        TFT_DISP,
    output logic        TFT_HSYNC,
    output logic        TFT_VSYNC,
    output logic        TFT_DE,
    output logic [23:0] TFT_RGB,
    output logic        FRAME_START,
    output logic        UNDERFLOW,
    output logic        SYNC_ERR
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {S_OFF, S_ALIGN, S_RUN} state_t;

    state_t        state, state_n;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_end, v_end, active, origin, hs, vs, on;
    logic          ready, uf_set, se_set;
    logic [23:0]   rgb_n;

    assign TFT_PCLK  = CLK;
    assign PIX_READY = ready;
    assign h_end     = h_cnt == H_LAST;
    assign v_end     = v_cnt == V_LAST;
    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign origin    = (h_cnt == '0) && (v_cnt == '0);
    assign hs        = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign vs        = (v_cnt >= V_SS) && (v_cnt < V_SE);
    assign on        = EN && (state != S_OFF);

`ifdef TFT_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int         bar_q;
    logic [2:0] bar;

    // Colour bar index from the horizontal position, clamped to the last bar
    always_comb begin
        bar_q = int'(h_cnt) / BAR_W;
        bar   = (bar_q > 7) ? 3'd7 : bar_q[2:0];
    end
`endif

    // Pixel/line counters run only while enabled, so re-enable always starts at the origin
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!EN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_OFF;
        else
            state <= state_n;
    end

    // Next state, stream handshake, pixel selection and status set conditions
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        rgb_n   = '0;
        uf_set  = 1'b0;
        se_set  = 1'b0;
        if (!EN)
            state_n = S_OFF;
        else begin
            case (state)
                S_OFF: state_n = S_ALIGN;
`ifdef TFT_TIMING_TEST_PATTERN_EN
                S_ALIGN: state_n = origin ? S_RUN : S_ALIGN;
                default: state_n = S_RUN;
`else
                S_ALIGN: begin
                    ready = PIX_VALID && (!PIX_SOF || origin);
                    if (PIX_VALID && PIX_SOF && origin) begin
                        state_n = S_RUN;
                        rgb_n   = PIX_DATA;
                    end
                end
                default: begin
                    if (active) begin
                        ready = !(PIX_VALID && PIX_SOF && !origin);
                        if (!PIX_VALID)
                            uf_set = 1'b1;
                        else if (PIX_SOF == origin)
                            rgb_n = PIX_DATA;
                        else begin
                            se_set  = 1'b1;
                            state_n = S_ALIGN;
                        end
                    end
                end
`endif
            endcase
        end
`ifdef TFT_TIMING_TEST_PATTERN_EN
        if (on && active)
            rgb_n = BARS[bar];
`endif
    end

    // Panel outputs registered one cycle behind the counters; forced idle when off or disabling
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TFT_DISP    <= 1'b0;
            TFT_HSYNC   <= 1'b1;
            TFT_VSYNC   <= 1'b1;
            TFT_DE      <= 1'b0;
            TFT_RGB     <= '0;
            FRAME_START <= 1'b0;
        end else begin
            TFT_DISP    <= on;
            TFT_HSYNC   <= !(on && hs);
            TFT_VSYNC   <= !(on && vs);
            TFT_DE      <= on && active;
            TFT_RGB     <= rgb_n;
            FRAME_START <= on && origin;
        end
    end

    // Sticky status flags; a new event takes priority over a clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            UNDERFLOW <= 1'b0;
            SYNC_ERR  <= 1'b0;
        end else begin
            UNDERFLOW <= uf_set || (UNDERFLOW && !CLR_STATUS);
            SYNC_ERR  <= se_set || (SYNC_ERR && !CLR_STATUS);
        end
    end
endmodule

// File: doc/tft_lcd_timing_gen.md
TFT_LCD_TIMING_GEN -- requirements
Module: tft_lcd_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 2 / 41 / 2, horizontal front porch, sync width and back porch in clocks.
REQ-003 Parameter V_ACTIVE, default 272, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 2 / 10 / 2, vertical porches and sync width in lines.
REQ-005 CLK  in  1  pixel clock; single clock domain; top level routes CLK to the panel as TFT_PCLK.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 EN  in  1  display enable.
REQ-008 PIX_VALID / PIX_READY  in / out  1 / 1  upstream pixel stream handshake.
REQ-009 PIX_DATA  in  24  RGB888 pixel.
REQ-010 PIX_SOF  in  1  marks first pixel of a frame; qualified by PIX_VALID.
REQ-011 TFT_DISP, TFT_HSYNC, TFT_VSYNC, TFT_DE  out  1 each  panel controls; HSYNC and VSYNC are active-low.
REQ-012 TFT_RGB  out  24  panel pixel data.
REQ-013 FRAME_START  out  1  one-cycle pulse at h=0, v=0.
REQ-014 UNDERFLOW, SYNC_ERR  out  1 each  sticky status flags, cleared by CLR_STATUS.
REQ-015 CLR_STATUS  in  1  synchronous clear of the sticky flags.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; counters h_cnt and v_cnt are each wide enough for its total.
REQ-017 Horizontal order: h_cnt 0..H_ACTIVE-1 active, then FP, then SYNC, then BP; h_cnt wraps to 0 at H_TOTAL-1 and advances v_cnt, which follows the same order and wraps at V_TOTAL-1.
REQ-018 Counters advance every cycle while EN=1; when EN=0 they are held at 0.
REQ-019 active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); hsync and vsync are asserted in their SYNC regions.
REQ-020 All TFT_* outputs and FRAME_START are registered and aligned, with one cycle of latency from the counter state.
REQ-021 State machine: OFF (EN=0) -> ALIGN (EN=1) -> RUN; EN=0 in any state -> OFF on the next cycle.
REQ-022 OFF: PIX_READY=0; TFT_DISP=0; HSYNC=VSYNC=1; DE=0; RGB=0.
REQ-023 ALIGN: PIX_READY=1 while PIX_VALID&&!PIX_SOF, discarding non-SOF pixels; at an SOF pixel PIX_READY=0 until h=0, v=0, where the pixel is accepted and the state becomes RUN.
REQ-024 ALIGN outputs valid timing with TFT_DISP=1, DE per active, and RGB=0.
REQ-025 RUN: PIX_READY = active; an accepted pixel drives TFT_RGB the next cycle.
REQ-026 RUN, active, PIX_VALID=0: TFT_RGB=0 for that pixel, UNDERFLOW set, the pixel slot is consumed and the timing does not stall.
REQ-027 RUN, h=0, v=0: an accepted pixel with PIX_SOF=0 sets SYNC_ERR, outputs RGB=0 and moves to ALIGN.
REQ-028 RUN, PIX_SOF=1 at any other active position sets SYNC_ERR and moves to ALIGN; the pixel is not consumed.
REQ-029 Outside active, TFT_RGB=0 and TFT_DE=0.
REQ-030 A status set and CLR_STATUS in the same cycle: the set wins.

Reset
REQ-031 On RST: state=OFF; h_cnt=v_cnt=0; TFT_DISP=0; TFT_HSYNC=TFT_VSYNC=1; TFT_DE=0; TFT_RGB=0; PIX_READY=0; FRAME_START=0; UNDERFLOW=SYNC_ERR=0.
REQ-032 RST mid-frame takes effect immediately (asynchronous); after release the block restarts from OFF/ALIGN and never resumes a partial frame.

Configuration
REQ-033 Macro TFT_TIMING_TEST_PATTERN_EN defined: in RUN and ALIGN, TFT_RGB outputs 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), each H_ACTIVE/8 pixels wide. PIX_READY=0, the stream is ignored and UNDERFLOW/SYNC_ERR are never set.
REQ-034 Macro undefined: stream behaviour per REQ-023..REQ-028, with no pattern logic synthesized.

Verification (small parameters: H 4/1/2/1, total 8; V 3/1/1/1, total 6)
REQ-035 RST, then EN=1, with no stream -> HSYNC low for exactly 2 of every 8 clocks, VSYNC low for exactly 8 clocks every 48, DE high 12 clocks per frame, and RGB=0.
REQ-036 Continuous valid stream, SOF on the pixel of value 0x000001, values incrementing -> frame shows 0x000001..0x00000C on DE cycles in order, with no flags set.
REQ-037 PIX_VALID dropped for pixel 5 of a frame -> RGB=0 on that DE cycle, UNDERFLOW=1, and later pixels keep their slots.
REQ-038 Three non-SOF pixels then SOF while in ALIGN -> the three are discarded, and the SOF pixel appears on the first DE of the next frame.
REQ-039 EN=0 mid-line -> next cycle DISP=0, HSYNC=VSYNC=1, DE=0; re-enable -> timing restarts at h=0, v=0.
REQ-040 SOF injected at active pixel 7 in RUN -> SYNC_ERR=1, then CLR_STATUS clears it, and the display realigns on the next frame.
